// File: rtl/audio_nios_sample_reader.sv
// Avalon-MM read master that streams sample words from on-chip memory into a
// show-ahead FIFO, exposed to the audio path as a valid/ready source.
module audio_nios_sample_reader #(
  parameter int ADDR_W     = 17,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  input  logic              loop,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  output logic [31:0]       src_data,
  output logic              src_valid,
  input  logic              src_ready,
  output logic [1:0]        dbg_state
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int SUM_W = CNT_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] remaining;
  logic              loop_q;
  logic              stop_q;
  logic [CNT_W-1:0]  pending;
  logic [CNT_W-1:0]  fifo_count;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [31:0]       mem [FIFO_DEPTH];

  logic              accept;
  logic              push;
  logic              pop;
  logic [CNT_W-1:0]  pend_nxt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              credit_nxt;

  // Handshakes: a read transfers on avm_read && !avm_waitrequest, and a
  // presented read stays put until it transfers; a stream word transfers on
  // src_valid && src_ready.
  always_comb begin
    accept     = avm_read && !avm_waitrequest;
    push       = avm_readdatavalid && (pending != '0);
    pop        = src_valid && src_ready;
    pend_nxt   = pending + {{(CNT_W-1){1'b0}}, accept} - {{(CNT_W-1){1'b0}}, push};
    cnt_nxt    = fifo_count + {{(CNT_W-1){1'b0}}, push} - {{(CNT_W-1){1'b0}}, pop};
    // Reserve FIFO space for every outstanding read so returns never overflow.
    credit_nxt = ({1'b0, pend_nxt} + {1'b0, cnt_nxt}) < SUM_W'(FIFO_DEPTH);
  end

  assign busy      = (state != S_IDLE);
  assign dbg_state = state;
  assign src_valid = (fifo_count != '0);
  assign src_data  = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= avm_readdata;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_count <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      base_q      <= '0;
      len_q       <= '0;
      remaining   <= '0;
      loop_q      <= 1'b0;
      stop_q      <= 1'b0;
      pending     <= '0;
      avm_address <= '0;
      avm_read    <= 1'b0;
      done        <= 1'b0;
    end else begin
      done    <= 1'b0;
      pending <= pend_nxt;
      case (state)
        S_IDLE: begin
          if (start && (length != '0)) begin
            base_q      <= base_addr;
            len_q       <= length;
            loop_q      <= loop;
            stop_q      <= 1'b0;
            avm_address <= base_addr;
            remaining   <= length;
            avm_read    <= credit_nxt;
            state       <= S_RUN;
          end
        end
        S_RUN: begin
          if (avm_read && avm_waitrequest) begin
            // Stalled request is held; remember a stop until it transfers.
            if (stop) stop_q <= 1'b1;
          end else begin
            if (accept) begin
              avm_address <= avm_address + ADDR_W'(1);
              remaining   <= remaining - ADDR_W'(1);
            end
            if (stop || stop_q) begin
              avm_read <= 1'b0;
              stop_q   <= 1'b0;
              state    <= S_DRAIN;
            end else if (accept && (remaining == ADDR_W'(1))) begin
              if (loop_q) begin
                avm_address <= base_q;
                remaining   <= len_q;
                avm_read    <= credit_nxt;
              end else begin
                avm_read <= 1'b0;
                state    <= S_DRAIN;
              end
            end else begin
              avm_read <= credit_nxt;
            end
          end
        end
        S_DRAIN: begin
          if ((pending == '0) && (fifo_count == '0)) begin
            state <= S_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_nios_sample_reader.sv
// Bench for audio_nios_sample_reader: table of transfers plus loop/stop and
// reset-with-outstanding-reads sequences, checked against an expected queue.
module tb_audio_nios_sample_reader;

  localparam int ADDR_W = 17;
  localparam int DEPTH  = 8;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic              stop;
  logic              loop;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] length;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_read;
  logic              avm_waitrequest;
  logic [31:0]       avm_readdata;
  logic              avm_readdatavalid;
  logic [31:0]       src_data;
  logic              src_valid;
  logic              src_ready;
  logic [1:0]        dbg_state;

  always #5 clk = ~clk;

  audio_nios_sample_reader #(.ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .start            (start),
    .stop             (stop),
    .loop             (loop),
    .base_addr        (base_addr),
    .length           (length),
    .busy             (busy),
    .done             (done),
    .avm_address      (avm_address),
    .avm_read         (avm_read),
    .avm_waitrequest  (avm_waitrequest),
    .avm_readdata     (avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .src_data         (src_data),
    .src_valid        (src_valid),
    .src_ready        (src_ready),
    .dbg_state        (dbg_state)
  );

  typedef struct {
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] len;
    int                stall;
    int                rdy;
    bit                hold_full;
    int                exp_reads;
    int                exp_rd_cycles;
    int                exp_done;
  } vec_t;

  typedef struct {
    int          due;
    logic [31:0] data;
  } ret_t;

  int checks = 0;
  int errors = 0;

  logic [31:0]       exp_q[$];
  logic [ADDR_W-1:0] exp_addr_q[$];
  ret_t              ret_q[$];

  int lat        = 1;
  int stall_mode = 0;
  int stall_left = 0;
  int rdy_mode   = 0;
  int acc_count  = 0;
  int rd_cycles  = 0;
  int pop_count  = 0;
  int done_count = 0;
  int busy_cycles = 0;
  int cyc        = 0;

  function automatic logic [31:0] data_of(input logic [ADDR_W-1:0] a);
    return {a[15:0] ^ 16'hA5A5, a[16:1] + 16'h1234};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory slave: waitrequest decided for the current cycle, then acceptance
  // recorded and the return beat scheduled lat cycles later.
  initial begin
    logic              w;
    logic              prev_hold;
    logic [ADDR_W-1:0] prev_addr;
    ret_t              r;
    avm_waitrequest   = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_readdata      = '0;
    prev_hold         = 1'b0;
    prev_addr         = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (prev_hold && reset_n) begin
        check("hold_read", {31'd0, avm_read}, 32'd1);
        check("hold_addr", {15'd0, avm_address}, {15'd0, prev_addr});
      end
      w = 1'b0;
      if (stall_mode == 1 && avm_read && acc_count == 1 && stall_left > 0) begin
        w = 1'b1;
        stall_left--;
      end else if (stall_mode == 2) begin
        w = ($urandom_range(0, 2) == 0);
      end
      avm_waitrequest = w;
      if (avm_read) rd_cycles++;
      prev_hold = avm_read && w && reset_n;
      prev_addr = avm_address;
      if (avm_read && !w) begin
        acc_count++;
        if (exp_addr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_read: got addr 0x%0h expected no read", avm_address);
        end else begin
          check("rd_addr", {15'd0, avm_address}, {15'd0, exp_addr_q.pop_front()});
        end
        r.due  = cyc + lat;
        r.data = data_of(avm_address);
        ret_q.push_back(r);
      end
      if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
        avm_readdatavalid = 1'b1;
        avm_readdata      = ret_q[0].data;
        void'(ret_q.pop_front());
      end else begin
        avm_readdatavalid = 1'b0;
        avm_readdata      = $urandom;
      end
    end
  end

  // Stream consumer and scoreboard.
  initial begin
    src_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       src_ready = 1'b1;
        1:       src_ready = 1'b0;
        default: src_ready = ($urandom_range(0, 1) == 1);
      endcase
      if (src_valid && exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_valid: got src_valid=1 data 0x%0h expected no word", src_data);
      end else if (src_valid && src_ready) begin
        pop_count++;
        check("src_data", src_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (busy) busy_cycles++;
      if (done) begin
        done_count++;
        check("busy_at_done", {31'd0, busy}, 32'd0);
      end
    end
  end

  task automatic pulse_start(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] n,
                             input logic lp);
    base_addr = b;
    length    = n;
    loop      = lp;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic clear_counts();
    acc_count   = 0;
    rd_cycles   = 0;
    pop_count   = 0;
    done_count  = 0;
    busy_cycles = 0;
  endtask

  task automatic push_expected(input logic [ADDR_W-1:0] b, input int n);
    logic [ADDR_W-1:0] a;
    for (int j = 0; j < n; j++) begin
      a = b + ADDR_W'(j);
      exp_addr_q.push_back(a);
      exp_q.push_back(data_of(a));
    end
  endtask

  task automatic run_vec(input vec_t v);
    int budget;
    clear_counts();
    stall_mode = v.stall;
    stall_left = 3;
    rdy_mode   = v.hold_full ? 1 : v.rdy;
    push_expected(v.base, int'(v.len));
    pulse_start(v.base, v.len, 1'b0);
    if (v.len != '0) begin
      check("start_busy", {31'd0, busy}, 32'd1);
      check("start_read", {31'd0, avm_read}, 32'd1);
      check("start_addr", {15'd0, avm_address}, {15'd0, v.base});
    end
    if (v.hold_full) begin
      repeat (40) @(negedge clk);
      check("full_reads", acc_count, 32'd8);
      check("full_read_low", {31'd0, avm_read}, 32'd0);
      check("full_valid", {31'd0, src_valid}, 32'd1);
      check("full_no_pop", pop_count, 32'd0);
      rdy_mode = 0;
    end
    budget = (v.exp_done != 0) ? 400 : 20;
    for (int t = 0; t < budget && done_count == 0; t++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("done_pulses", done_count, v.exp_done);
    check("reads_accepted", acc_count, v.exp_reads);
    if (v.exp_rd_cycles >= 0) check("read_cycles", rd_cycles, v.exp_rd_cycles);
    check("undelivered", exp_q.size(), 32'd0);
    check("busy_after", {31'd0, busy}, 32'd0);
    if (v.len == '0) check("len0_busy_cycles", busy_cycles, 32'd0);
    stall_mode = 0;
    exp_q.delete();
    exp_addr_q.delete();
  endtask

  initial begin
    vec_t vecs[6];
    vec_t post;
    int   acc_at_stop;
    int   acc_after;

    reset_n   = 1'b1;
    start     = 1'b0;
    stop      = 1'b0;
    loop      = 1'b0;
    base_addr = '0;
    length    = '0;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_read", {31'd0, avm_read}, 32'd0);
    check("rst_addr", {15'd0, avm_address}, 32'd0);
    check("rst_valid", {31'd0, src_valid}, 32'd0);
    check("rst_data", src_data, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    vecs[0] = '{17'h00100, 17'd4,  0, 0, 1'b0, 4,  4,  1};
    vecs[1] = '{17'h00100, 17'd4,  1, 0, 1'b0, 4,  7,  1};
    vecs[2] = '{17'h00200, 17'd20, 0, 0, 1'b1, 20, 20, 1};
    vecs[3] = '{17'h1FFFF, 17'd2,  0, 0, 1'b0, 2,  2,  1};
    vecs[4] = '{17'h00040, 17'd0,  0, 0, 1'b0, 0,  0,  0};
    vecs[5].base          = ADDR_W'($urandom_range(0, 17'h1FFFF));
    vecs[5].len           = ADDR_W'($urandom_range(5, 12));
    vecs[5].stall         = 2;
    vecs[5].rdy           = 2;
    vecs[5].hold_full     = 1'b0;
    vecs[5].exp_reads     = int'(vecs[5].len);
    vecs[5].exp_rd_cycles = -1;
    vecs[5].exp_done      = 1;

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Looping transfer terminated by stop.
    clear_counts();
    rdy_mode = 0;
    for (int k = 0; k < 10; k++) push_expected(17'h00010, 3);
    pulse_start(17'h00010, 17'd3, 1'b1);
    for (int t = 0; t < 50 && acc_count < 7; t++) @(negedge clk);
    stop = 1'b1;
    acc_at_stop = acc_count;
    @(negedge clk);
    stop = 1'b0;
    for (int t = 0; t < 100 && done_count == 0; t++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("loop_done", done_count, 32'd1);
    check("loop_reads_ge7", {31'd0, acc_count >= 7}, 32'd1);
    check("loop_stop_window", {31'd0, (acc_count - acc_at_stop) <= 1}, 32'd1);
    check("loop_delivered", pop_count, acc_count);
    acc_after = acc_count;
    repeat (10) @(negedge clk);
    check("loop_no_more_reads", acc_count, acc_after);
    check("loop_busy_after", {31'd0, busy}, 32'd0);
    exp_q.delete();
    exp_addr_q.delete();

    // Reset with reads outstanding; late returns must be discarded.
    clear_counts();
    lat = 6;
    push_expected(17'h00300, 8);
    pulse_start(17'h00300, 17'd8, 1'b0);
    for (int t = 0; t < 20 && acc_count < 3; t++) @(negedge clk);
    @(negedge clk);
    #2 reset_n = 1'b0;
    exp_q.delete();
    exp_addr_q.delete();
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_read", {31'd0, avm_read}, 32'd0);
    check("arst_addr", {15'd0, avm_address}, 32'd0);
    check("arst_valid", {31'd0, src_valid}, 32'd0);
    check("arst_data", src_data, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    #2 reset_n = 1'b1;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      check("straggler_valid", {31'd0, src_valid}, 32'd0);
    end
    for (int t = 0; t < 40 && ret_q.size() != 0; t++) @(negedge clk);
    check("stragglers_gone", ret_q.size(), 32'd0);
    lat = 1;

    post = '{17'h00300, 17'd3, 0, 0, 1'b0, 3, 3, 1};
    run_vec(post);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/audio_nios_sample_reader.md
# audio_nios_sample_reader

Avalon-MM read master that fetches 32-bit stereo sample words from the Nios on-chip sample memory and presents them as a valid/ready stream to the audio output path. Software programs a base word address and length, pulses `start`, and the block issues pipelined reads, buffers returned data in a small FIFO, and optionally loops over the buffer until stopped.

## Interface
- `ADDR_W`, 17: word-address width; matches the on-chip memory slave address.
- `FIFO_DEPTH`, 8: return-data FIFO depth in words; power of two, at least 2.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a transfer; sampled only in IDLE.
- `stop`  in  1  end a looping or running transfer after in-flight reads complete.
- `loop`  in  1  latched at start; 1 = restart at base after last word.
- `base_addr`  in  ADDR_W  first word address; latched at start.
- `length`  in  ADDR_W  word count; latched at start; 0 = start ignored.
- `busy`  out  1  high whenever state is not IDLE.
- `done`  out  1  one-cycle pulse on completion.
- `avm_address`  out  ADDR_W  read word address.
- `avm_read`  out  1  read request.
- `avm_waitrequest`  in  1  slave stall; request must be held.
- `avm_readdata`  in  32  return data, bits [31:16] left, [15:0] right.
- `avm_readdatavalid`  in  1  `avm_readdata` valid this cycle.
- `src_data`  out  32  FIFO head word.
- `src_valid`  out  1  FIFO not empty.
- `src_ready`  in  1  consumer accepts head word this cycle.

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: `start` with `length != 0` latches base/length/loop, loads addr = base, remaining = length, goes RUN. `start` with `length == 0`: ignored, no reads, no `done`.
- RUN: `avm_read` asserted when credit available: `pending + fifo_count < FIFO_DEPTH`. A read is accepted when `avm_read && !avm_waitrequest`; on acceptance addr increments (wraps modulo 2^ADDR_W), remaining decrements, pending increments.
- While `avm_waitrequest` high, `avm_read` and `avm_address` held stable; credit loss or `stop` never withdraws a presented request.
- Last word accepted (remaining 1 -> 0): if loop and not stop, reload addr = base, remaining = latched length, stay RUN; else go DRAIN.
- `stop` in RUN: no new request launched after current one (if any) is accepted; go DRAIN. `stop` in IDLE/DRAIN: no effect.
- DRAIN: no reads; when `pending == 0` and FIFO empty, go IDLE, pulse `done`.
- `avm_readdatavalid` pushes `avm_readdata` into FIFO and decrements pending; when pending == 0 the beat is discarded (post-reset stragglers).
- FIFO is show-ahead: `src_data` = head, `src_valid` = not empty; pop on `src_valid && src_ready`. Simultaneous push and pop leaves count unchanged. Credit rule guarantees no overflow; no push is ever dropped.
- `start` while busy is ignored.
- Counters: pending and fifo_count are clog2(FIFO_DEPTH)+1 bits.

## Timing
- Reset values: state IDLE; `busy`, `done`, `avm_read`, `src_valid` = 0; `avm_address`, `src_data` = 0; FIFO, pending, counters cleared.
- `start` sampled at edge N -> `busy` and `avm_read` high after edge N, `avm_address` = base.
- No stall, credit available: one read accepted per cycle, back-to-back.
- `avm_readdatavalid` at edge M -> `src_valid` high after edge M (one cycle FIFO latency).
- `done` high for exactly the cycle following the DRAIN->IDLE edge; `busy` low in that same cycle.
- `reset_n` low mid-transfer: all outputs to reset values immediately (asynchronous), FIFO contents lost.

## Test plan
- Slave latency 1, no waitrequest, base 0x100, length 4, `src_ready`=1 -> reads to 0x100..0x103 on 4 consecutive cycles, 4 words out in order, one `done` pulse, `busy` low after.
- `avm_waitrequest` high 3 cycles on second read -> address 0x101 and `avm_read` held 3+1 cycles, exactly 4 reads accepted, data order unchanged.
- `src_ready`=0, length 20, FIFO_DEPTH 8 -> exactly 8 reads accepted then `avm_read` low; FIFO full; raise `src_ready` -> all 20 words delivered in order, no loss.
- `loop`=1, base 0x10, length 3 -> address sequence 0x10,0x11,0x12,0x10,...; assert `stop` -> in-flight data delivered, `done` pulses, no further reads.
- base 0x1FFFF, length 2 -> addresses 0x1FFFF then 0x00000; `start` with length 0 -> no read, no `done`, `busy` stays 0.
- `reset_n` low with 3 reads pending -> outputs zero immediately; after release, straggling `avm_readdatavalid` beats discarded, `src_valid` stays 0.
